exc_ctrl: RTL and testbench
===========================

EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, default 32'h0000_0020, exception handler entry address.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 mem_valid_i  in  1  MEM-stage instruction valid.
REQ-005 mem_pc_i  in  32  MEM-stage instruction address.
REQ-006 mem_in_delayslot_i  in  1  MEM instruction sits in a branch delay slot.
REQ-007 mem_syscall_i / mem_ri_i / mem_ov_i / mem_eret_i  in  1 each  syscall, reserved instruction, overflow, eret flags.
REQ-008 cp0_status_i / cp0_cause_i / cp0_epc_i  in  32 each  current CP0 register values.
REQ-009 wb_cp0_we_i  in  1, wb_cp0_waddr_i  in  5, wb_cp0_wdata_i  in  32  pending CP0 write for bypass.
REQ-010 int_req_i  in  1  external interrupt request, level.
REQ-011 except_o  out  32  exception code to CP0.
REQ-012 cur_inst_addr_o  out  32  faulting PC to CP0; in_delayslot_o  out  1  delay-slot flag to CP0.
REQ-013 flush_o  out  1  pipeline flush pulse; new_pc_o  out  32  redirect target; busy_o  out  1  FSM not IDLE.

Function
REQ-014 Effective status/epc: wdata when wb_cp0_we_i and waddr = 12/14, else CP0 input.
REQ-015 Effective cause: cp0_cause_i with bits [9:8] from wdata when wb_cp0_we_i and waddr = 13.
REQ-016 Interrupt taken iff mem_valid_i, status[0]=1, status[1]=0, and ((cause[15:8] & status[15:8]) != 0 or pend = 1).
REQ-017 Priority, highest first: interrupt 32'h1, RI 32'ha, overflow 32'hc, syscall 32'h8, eret 32'he; ignore flags when mem_valid_i = 0.
REQ-018 except_o combinational in IDLE: selected code, else 0; forced 0 in FLUSH and DRAIN.
REQ-019 cur_inst_addr_o = mem_pc_i, in_delayslot_o = mem_in_delayslot_i, combinationally, every cycle.
REQ-020 FSM states IDLE, FLUSH, DRAIN; IDLE->FLUSH on edge where except_o != 0; FLUSH->DRAIN unconditionally; DRAIN->IDLE unconditionally.
REQ-021 flush_o registered, 1 in FLUSH only: exactly one cycle, one cycle after except_o != 0.
REQ-022 new_pc_o latched on IDLE->FLUSH edge: effective epc for code 32'he, EXC_VECTOR otherwise; held until next capture.
REQ-023 busy_o = 1 in FLUSH and DRAIN.
REQ-024 Exceptions presented during FLUSH/DRAIN are dropped, not queued.
REQ-025 Simultaneous eret and other flag: higher-priority code wins, eret dropped.

Reset
REQ-026 rst=0 at an edge: state IDLE, flush_o 0, new_pc_o 0, pend 0, regardless of current state.
REQ-027 While rst=0: except_o 0, busy_o 0; reset mid-FLUSH suppresses the flush pulse from next cycle.

Configuration
REQ-028 Macro EXC_INT_LATCH_EN defined: pend set by int_req_i=1 at any edge, cleared on edge taking code 32'h1; pend feeds REQ-016.
REQ-029 EXC_INT_LATCH_EN undefined: pend constant 0, int_req_i ignored; interrupts only via cause/status bits.

Verification
REQ-030 mem_valid=1, mem_ov=1, pc=32'h100, status=0 -> except_o=32'hc, cur_inst_addr=32'h100; next cycle flush_o=1, new_pc_o=32'h20; busy_o 1 for 2 cycles.
REQ-031 mem_eret=1, cp0_epc=32'h40, WB writes epc=32'h80 same cycle -> except_o=32'he; next cycle new_pc_o=32'h80.
REQ-032 status=32'h0000_0401, cause[10]=1, mem_ri=1 -> except_o=32'h1 (interrupt beats RI); with status[1]=1 -> except_o=32'ha.
REQ-033 mem_syscall=1 for 3 consecutive cycles -> one except_o=32'h8, single flush pulse, cycles 2-3 except_o=0.
REQ-034 rst=0 asserted during FLUSH -> flush_o=0 next cycle, state IDLE; with EXC_INT_LATCH_EN, int_req_i one-cycle pulse, status=32'h1 -> except_o=32'h1 on later valid cycle.

Source files
------------

// File: rtl/exc_if.sv
// Handshake bundle between the MEM stage, CP0 and the exception controller.
interface exc_if;
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_delayslot_i;
    logic        mem_syscall_i;
    logic        mem_ri_i;
    logic        mem_ov_i;
    logic        mem_eret_i;
    logic [31:0] cp0_status_i;
    logic [31:0] cp0_cause_i;
    logic [31:0] cp0_epc_i;
    logic        wb_cp0_we_i;
    logic [4:0]  wb_cp0_waddr_i;
    logic [31:0] wb_cp0_wdata_i;
    logic        int_req_i;
    logic [31:0] except_o;
    logic [31:0] cur_inst_addr_o;
    logic        in_delayslot_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        busy_o;

    modport master (
        output mem_valid_i, mem_pc_i, mem_in_delayslot_i, mem_syscall_i, mem_ri_i, mem_ov_i,
               mem_eret_i, cp0_status_i, cp0_cause_i, cp0_epc_i, wb_cp0_we_i, wb_cp0_waddr_i,
               wb_cp0_wdata_i, int_req_i,
        input  except_o, cur_inst_addr_o, in_delayslot_o, flush_o, new_pc_o, busy_o
    );

    modport slave (
        input  mem_valid_i, mem_pc_i, mem_in_delayslot_i, mem_syscall_i, mem_ri_i, mem_ov_i,
               mem_eret_i, cp0_status_i, cp0_cause_i, cp0_epc_i, wb_cp0_we_i, wb_cp0_waddr_i,
               wb_cp0_wdata_i, int_req_i,
        output except_o, cur_inst_addr_o, in_delayslot_o, flush_o, new_pc_o, busy_o
    );
endinterface

// File: rtl/exc_ctrl.sv
// Exception controller: prioritises MEM-stage exceptions, then flushes and redirects the pipe.
// Optional interrupt-request latch enabled by defining EXC_INT_LATCH_EN.
module exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
    input logic  clk,
    input logic  rst,
    exc_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StFlush, StDrain} state_e;

    localparam logic [4:0] AddrStatus = 5'd12;
    localparam logic [4:0] AddrCause  = 5'd13;
    localparam logic [4:0] AddrEpc    = 5'd14;

    localparam logic [31:0] CodeInt     = 32'h0000_0001;
    localparam logic [31:0] CodeSyscall = 32'h0000_0008;
    localparam logic [31:0] CodeRi      = 32'h0000_000a;
    localparam logic [31:0] CodeOv      = 32'h0000_000c;
    localparam logic [31:0] CodeEret    = 32'h0000_000e;

    state_e      state_q;
    logic        flush_q;
    logic [31:0] new_pc_q;
    logic        pend;

    logic [31:0] status_eff;
    logic [31:0] epc_eff;
    logic [7:0]  cause_ip;
    logic        int_take;
    logic [31:0] code;
    logic [31:0] except;

    // CP0 writes still in WB are bypassed so back-to-back mtc0/exception sees fresh values.
    assign status_eff = (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == AddrStatus) ?
                        bus.wb_cp0_wdata_i : bus.cp0_status_i;
    assign epc_eff    = (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == AddrEpc) ?
                        bus.wb_cp0_wdata_i : bus.cp0_epc_i;
    assign cause_ip   = (bus.wb_cp0_we_i && bus.wb_cp0_waddr_i == AddrCause) ?
                        {bus.cp0_cause_i[15:10], bus.wb_cp0_wdata_i[9:8]} : bus.cp0_cause_i[15:8];

    assign int_take = bus.mem_valid_i && status_eff[0] && !status_eff[1] &&
                      (((cause_ip & status_eff[15:8]) != 8'h00) || pend);

    always_comb begin
        code = 32'h0;
        if (bus.mem_valid_i) begin
            if (int_take)               code = CodeInt;
            else if (bus.mem_ri_i)      code = CodeRi;
            else if (bus.mem_ov_i)      code = CodeOv;
            else if (bus.mem_syscall_i) code = CodeSyscall;
            else if (bus.mem_eret_i)    code = CodeEret;
        end
    end

    assign except = (rst && state_q == StIdle) ? code : 32'h0;

    assign bus.except_o        = except;
    assign bus.cur_inst_addr_o = bus.mem_pc_i;
    assign bus.in_delayslot_o  = bus.mem_in_delayslot_i;
    assign bus.flush_o         = flush_q;
    assign bus.new_pc_o        = new_pc_q;
    assign bus.busy_o          = rst && (state_q != StIdle);

`ifdef EXC_INT_LATCH_EN
    logic pend_q;
    assign pend = pend_q;
    logic unused_ok;
    assign unused_ok = ^{status_eff[31:16], status_eff[7:2], bus.cp0_cause_i[31:16],
                         bus.cp0_cause_i[9:0]};
`else
    assign pend = 1'b0;
    logic unused_ok;
    assign unused_ok = ^{status_eff[31:16], status_eff[7:2], bus.cp0_cause_i[31:16],
                         bus.cp0_cause_i[9:0], bus.int_req_i};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            flush_q  <= 1'b0;
            new_pc_q <= 32'h0;
`ifdef EXC_INT_LATCH_EN
            pend_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (except != 32'h0) begin
                        state_q  <= StFlush;
                        flush_q  <= 1'b1;
                        new_pc_q <= (except == CodeEret) ? epc_eff : EXC_VECTOR;
                    end
                end
                StFlush: begin
                    state_q <= StDrain;
                    flush_q <= 1'b0;
                end
                StDrain: begin
                    state_q <= StIdle;
                    flush_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    flush_q <= 1'b0;
                end
            endcase
`ifdef EXC_INT_LATCH_EN
            // A still-asserted request re-arms the latch even on the edge that takes it.
            if (bus.int_req_i)                 pend_q <= 1'b1;
            else if (except == CodeInt)        pend_q <= 1'b0;
`endif
        end
    end
endmodule

// File: tb/tb_exc_ctrl.sv
// Directed-vector bench for exc_ctrl with hand-computed expectations.
module tb_exc_ctrl;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    int   pulses;

    exc_if bus ();

    exc_ctrl #(.EXC_VECTOR(32'h0000_0020)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.mem_valid_i        = 1'b0;
        bus.mem_pc_i           = 32'h0;
        bus.mem_in_delayslot_i = 1'b0;
        bus.mem_syscall_i      = 1'b0;
        bus.mem_ri_i           = 1'b0;
        bus.mem_ov_i           = 1'b0;
        bus.mem_eret_i         = 1'b0;
        bus.cp0_status_i       = 32'h0;
        bus.cp0_cause_i        = 32'h0;
        bus.cp0_epc_i          = 32'h0;
        bus.wb_cp0_we_i        = 1'b0;
        bus.wb_cp0_waddr_i     = 5'd0;
        bus.wb_cp0_wdata_i     = 32'h0;
        bus.int_req_i          = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        pulses      = 0;
        clear_inputs();
        rst = 1'b0;
        bus.mem_valid_i = 1'b1;
        bus.mem_ov_i    = 1'b1;
        tick();
        tick();
        check("rst_except", bus.except_o, 32'h0);
        check("rst_busy", {31'h0, bus.busy_o}, 32'h0);
        check("rst_flush", {31'h0, bus.flush_o}, 32'h0);
        check("rst_newpc", bus.new_pc_o, 32'h0);
        clear_inputs();
        rst = 1'b1;
        tick();

        // Overflow: code, redirect to vector, two busy cycles, new exceptions dropped.
        bus.mem_valid_i        = 1'b1;
        bus.mem_ov_i           = 1'b1;
        bus.mem_pc_i           = 32'h100;
        bus.mem_in_delayslot_i = 1'b1;
        settle();
        check("ov_code", bus.except_o, 32'hc);
        check("ov_pc", bus.cur_inst_addr_o, 32'h100);
        check("ov_ds", {31'h0, bus.in_delayslot_o}, 32'h1);
        tick();
        check("ov_flush", {31'h0, bus.flush_o}, 32'h1);
        check("ov_newpc", bus.new_pc_o, 32'h20);
        check("ov_busy1", {31'h0, bus.busy_o}, 32'h1);
        check("flush_except0", bus.except_o, 32'h0);
        tick();
        check("drain_flush", {31'h0, bus.flush_o}, 32'h0);
        check("drain_busy", {31'h0, bus.busy_o}, 32'h1);
        check("drain_except0", bus.except_o, 32'h0);
        clear_inputs();
        tick();
        check("idle_busy", {31'h0, bus.busy_o}, 32'h0);
        check("idle_flush", {31'h0, bus.flush_o}, 32'h0);
        check("hold_newpc", bus.new_pc_o, 32'h20);

        // eret with EPC bypassed from WB.
        bus.mem_valid_i    = 1'b1;
        bus.mem_eret_i     = 1'b1;
        bus.cp0_epc_i      = 32'h40;
        bus.wb_cp0_we_i    = 1'b1;
        bus.wb_cp0_waddr_i = 5'd14;
        bus.wb_cp0_wdata_i = 32'h80;
        settle();
        check("eret_code", bus.except_o, 32'he);
        tick();
        check("eret_newpc", bus.new_pc_o, 32'h80);
        clear_inputs();
        tick();
        tick();

        // Interrupt vs RI, EXL masking, status/cause bypass.
        bus.mem_valid_i  = 1'b1;
        bus.mem_ri_i     = 1'b1;
        bus.cp0_status_i = 32'h0000_0401;
        bus.cp0_cause_i  = 32'h0000_0400;
        settle();
        check("int_beats_ri", bus.except_o, 32'h1);
        bus.cp0_status_i = 32'h0000_0403;
        settle();
        check("exl_masks_int", bus.except_o, 32'ha);
        bus.cp0_status_i   = 32'h0;
        bus.wb_cp0_we_i    = 1'b1;
        bus.wb_cp0_waddr_i = 5'd12;
        bus.wb_cp0_wdata_i = 32'h0000_0401;
        settle();
        check("status_bypass", bus.except_o, 32'h1);
        bus.mem_ri_i       = 1'b0;
        bus.cp0_cause_i    = 32'h0;
        bus.cp0_status_i   = 32'h0000_0101;
        bus.wb_cp0_waddr_i = 5'd13;
        bus.wb_cp0_wdata_i = 32'h0000_0100;
        settle();
        check("cause_bypass", bus.except_o, 32'h1);
        bus.wb_cp0_we_i = 1'b0;
        settle();
        check("cause_no_bypass", bus.except_o, 32'h0);
        clear_inputs();

        // Priority among synchronous flags and valid gating.
        bus.mem_valid_i   = 1'b1;
        bus.mem_ov_i      = 1'b1;
        bus.mem_syscall_i = 1'b1;
        settle();
        check("ov_over_sys", bus.except_o, 32'hc);
        bus.mem_ov_i   = 1'b0;
        bus.mem_eret_i = 1'b1;
        settle();
        check("sys_over_eret", bus.except_o, 32'h8);
        bus.mem_syscall_i = 1'b0;
        bus.mem_ov_i      = 1'b1;
        bus.cp0_epc_i     = 32'h1234;
        settle();
        check("ov_over_eret", bus.except_o, 32'hc);
        tick();
        check("ov_eret_newpc", bus.new_pc_o, 32'h20);
        clear_inputs();
        tick();
        tick();
        bus.mem_ri_i   = 1'b1;
        bus.mem_eret_i = 1'b1;
        settle();
        check("invalid_ignored", bus.except_o, 32'h0);
        clear_inputs();

        // Syscall held three cycles: one code, one flush pulse.
        bus.mem_valid_i   = 1'b1;
        bus.mem_syscall_i = 1'b1;
        settle();
        check("sys_c1", bus.except_o, 32'h8);
        tick();
        pulses += int'(bus.flush_o);
        check("sys_c2", bus.except_o, 32'h0);
        tick();
        pulses += int'(bus.flush_o);
        check("sys_c3", bus.except_o, 32'h0);
        clear_inputs();
        tick();
        pulses += int'(bus.flush_o);
        tick();
        pulses += int'(bus.flush_o);
        check("sys_pulses", pulses, 32'd1);

        // Reset while in FLUSH.
        bus.mem_valid_i = 1'b1;
        bus.mem_ov_i    = 1'b1;
        tick();
        check("pre_rst_flush", {31'h0, bus.flush_o}, 32'h1);
        rst = 1'b0;
        settle();
        check("rstmid_busy", {31'h0, bus.busy_o}, 32'h0);
        check("rstmid_except", bus.except_o, 32'h0);
        tick();
        check("rstmid_flush", {31'h0, bus.flush_o}, 32'h0);
        check("rstmid_newpc", bus.new_pc_o, 32'h0);
        clear_inputs();
        rst = 1'b1;
        tick();
        check("rstmid_idle", {31'h0, bus.busy_o}, 32'h0);

`ifdef EXC_INT_LATCH_EN
        bus.cp0_status_i = 32'h1;
        bus.int_req_i    = 1'b1;
        tick();
        bus.int_req_i = 1'b0;
        tick();
        bus.mem_valid_i = 1'b1;
        settle();
        check("pend_int", bus.except_o, 32'h1);
        tick();
        bus.mem_valid_i = 1'b0;
        tick();
        tick();
        bus.mem_valid_i = 1'b1;
        settle();
        check("pend_cleared", bus.except_o, 32'h0);
`else
        bus.cp0_status_i = 32'h1;
        bus.mem_valid_i  = 1'b1;
        bus.int_req_i    = 1'b1;
        settle();
        check("intreq_ignored", bus.except_o, 32'h0);
        tick();
        bus.int_req_i = 1'b0;
        settle();
        check("intreq_no_pend", bus.except_o, 32'h0);
`endif
        clear_inputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
